// File: rtl/multi_channel_clock_divider.sv
// N-channel programmable clock divider / PWM generator with double-buffered period, high-time and phase.
// Optional build macro CLKDIV_PHASE_EN enables per-channel phase offset storage.
module multi_channel_clock_divider #(
    parameter int NUM_CH        = 4,
    parameter int COUNTER_WIDTH = 26,
    parameter int CH_SEL_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     CLOCK_IN,
    input  logic                     async_reset,
    input  logic                     cfg_we,
    input  logic [CH_SEL_W-1:0]      cfg_ch,
    input  logic [COUNTER_WIDTH-1:0] cfg_divider,
    input  logic [COUNTER_WIDTH-1:0] cfg_high,
    input  logic [COUNTER_WIDTH-1:0] cfg_phase,
    input  logic [NUM_CH-1:0]        ch_enable,
    input  logic                     sync_restart,
    output logic [NUM_CH-1:0]        CLOCK_OUT,
    output logic [NUM_CH-1:0]        PERIOD_TICK,
    output logic [NUM_CH-1:0]        cfg_pending
);

`ifndef CLKDIV_PHASE_EN
    logic w_unused_phase;
    assign w_unused_phase = ^cfg_phase;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [COUNTER_WIDTH-1:0] r_sh_d, r_sh_h, r_act_d, r_act_h, r_cnt;
        logic                     r_pend, r_clk, r_tick;
        logic                     w_wr, w_en, w_wrap, w_load;
        logic [COUNTER_WIDTH-1:0] w_eff_sh, w_eff_act, w_eff_cm;

`ifdef CLKDIV_PHASE_EN
        logic [COUNTER_WIDTH-1:0] r_sh_p, r_act_p;
        // A phase outside the period would never reach the wrap compare, so fall back to 0.
        assign w_eff_sh  = (r_sh_p < r_sh_d) ? r_sh_p : '0;
        assign w_eff_act = (r_act_p < r_act_d) ? r_act_p : '0;
`else
        assign w_eff_sh  = '0;
        assign w_eff_act = '0;
`endif

        assign w_wr   = cfg_we && (cfg_ch == CH_SEL_W'(i));
        assign w_en   = ch_enable[i];
        assign w_wrap = (r_act_d != '0) && (r_cnt == r_act_d - 1'b1);
        // Shadow moves to active while idle, or at a restart / stopped / period boundary.
        assign w_load = !w_en || (r_pend && (sync_restart || (r_act_d == '0) || w_wrap));
        assign w_eff_cm = w_load ? w_eff_sh : w_eff_act;

        always_ff @(negedge CLOCK_IN or negedge async_reset) begin
            if (!async_reset) begin
                r_sh_d  <= '0;
                r_sh_h  <= '0;
                r_act_d <= '0;
                r_act_h <= '0;
                r_cnt   <= '0;
                r_pend  <= 1'b0;
                r_clk   <= 1'b0;
                r_tick  <= 1'b0;
`ifdef CLKDIV_PHASE_EN
                r_sh_p  <= '0;
                r_act_p <= '0;
`endif
            end else begin
                if (w_load) begin
                    r_act_d <= r_sh_d;
                    r_act_h <= r_sh_h;
`ifdef CLKDIV_PHASE_EN
                    r_act_p <= r_sh_p;
`endif
                end
                if (w_wr) begin
                    r_sh_d <= cfg_divider;
                    r_sh_h <= cfg_high;
`ifdef CLKDIV_PHASE_EN
                    r_sh_p <= cfg_phase;
`endif
                    r_pend <= 1'b1;
                end else if (w_load) begin
                    r_pend <= 1'b0;
                end

                r_clk  <= w_en && (r_act_d != '0) && (r_cnt < r_act_h);
                r_tick <= 1'b0;
                if (!w_en || sync_restart) begin
                    r_cnt <= w_eff_cm;
                end else if (r_act_d == '0) begin
                    r_cnt <= '0;
                end else if (w_wrap) begin
                    r_cnt  <= '0;
                    r_tick <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign CLOCK_OUT[i]   = r_clk;
        assign PERIOD_TICK[i] = r_tick;
        assign cfg_pending[i] = r_pend;
    end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// Self-checking bench for multi_channel_clock_divider: scripted sequences through an expected queue
// plus a table of degenerate period/high-time settings.
module tb_multi_channel_clock_divider;
    localparam int NC = 6;
    localparam int CW = 26;
    localparam int SW = 3;
`ifdef CLKDIV_PHASE_EN
    localparam bit PH = 1'b1;
`else
    localparam bit PH = 1'b0;
`endif

    logic          CLOCK_IN = 1'b0;
    logic          async_reset;
    logic          cfg_we;
    logic [SW-1:0] cfg_ch;
    logic [CW-1:0] cfg_divider, cfg_high, cfg_phase;
    logic [NC-1:0] ch_enable;
    logic          sync_restart;
    logic [NC-1:0] CLOCK_OUT, PERIOD_TICK, cfg_pending;

    int total = 0;
    int bad   = 0;
    logic [3*NC-1:0] exp_q[$];
    string           nm_q[$];

    typedef struct {
        int d;
        int h;
        int exp_hi;
        int exp_tk;
    } vec_t;
    vec_t vecs[8];

    multi_channel_clock_divider #(
        .NUM_CH(NC),
        .COUNTER_WIDTH(CW)
    ) dut (
        .CLOCK_IN(CLOCK_IN),
        .async_reset(async_reset),
        .cfg_we(cfg_we),
        .cfg_ch(cfg_ch),
        .cfg_divider(cfg_divider),
        .cfg_high(cfg_high),
        .cfg_phase(cfg_phase),
        .ch_enable(ch_enable),
        .sync_restart(sync_restart),
        .CLOCK_OUT(CLOCK_OUT),
        .PERIOD_TICK(PERIOD_TICK),
        .cfg_pending(cfg_pending)
    );

    // clock / reset
    always #5 CLOCK_IN = ~CLOCK_IN;

    function automatic logic [NC-1:0] two(input logic b0, input logic b1);
        logic [NC-1:0] v;
        v = '0;
        v[0] = b0;
        v[1] = b1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // driver tasks
    task automatic wr(input int ch, input int d, input int h, input int p);
        cfg_we      = 1'b1;
        cfg_ch      = SW'(ch);
        cfg_divider = CW'(d);
        cfg_high    = CW'(h);
        cfg_phase   = CW'(p);
    endtask

    task automatic idle();
        cfg_we = 1'b0;
    endtask

    // scoreboard: push expectation for the coming falling edge, pop at the following rising edge
    task automatic step(input logic [NC-1:0] ec, input logic [NC-1:0] et,
                        input logic [NC-1:0] ep, input string nm);
        logic [3*NC-1:0] g, e;
        string n;
        exp_q.push_back({ec, et, ep});
        nm_q.push_back(nm);
        @(posedge CLOCK_IN);
        g = {CLOCK_OUT, PERIOD_TICK, cfg_pending};
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        chk(n, 32'(g), 32'(e));
    endtask

    initial begin
        int c, c1, hi, tk;
        vecs[0] = '{d: 0,  h: 5,  exp_hi: 0,  exp_tk: 0};
        vecs[1] = '{d: 1,  h: 1,  exp_hi: 20, exp_tk: 20};
        vecs[2] = '{d: 1,  h: 0,  exp_hi: 0,  exp_tk: 20};
        vecs[3] = '{d: 10, h: 12, exp_hi: 20, exp_tk: 2};
        vecs[4] = '{d: 10, h: 0,  exp_hi: 0,  exp_tk: 2};
        vecs[5] = '{d: 5,  h: 2,  exp_hi: 8,  exp_tk: 4};
        vecs[6] = '{d: 7,  h: 3,  exp_hi: 9,  exp_tk: 2};
        vecs[7] = '{d: 20, h: 20, exp_hi: 20, exp_tk: 1};

        async_reset  = 1'b0;
        cfg_we       = 1'b0;
        cfg_ch       = '0;
        cfg_divider  = '0;
        cfg_high     = '0;
        cfg_phase    = '0;
        ch_enable    = '0;
        sync_restart = 1'b0;
        repeat (3) @(posedge CLOCK_IN);
        chk("reset_state", 32'({CLOCK_OUT, PERIOD_TICK, cfg_pending}), 32'd0);
        async_reset = 1'b1;

        // basic D=10 H=3 on ch0
        wr(0, 10, 3, 0);
        step('0, '0, two(1, 0), "t1_write");
        idle();
        ch_enable = two(1, 0);
        step('0, '0, '0, "t1_commit");
        for (int k = 2; k <= 26; k++) begin
            c = (k - 2) % 10;
            step(two(c < 3, 0), two(c == 9, 0), '0, $sformatf("t1_run_%0d", k));
        end

        // mid-period reconfiguration to D=4 H=2
        wr(0, 4, 2, 0);
        step('0, '0, two(1, 0), "t2_write");
        idle();
        for (int k = 28; k <= 30; k++) step('0, '0, two(1, 0), $sformatf("t2_old_%0d", k));
        step('0, two(1, 0), '0, "t2_wrap");
        for (int j = 0; j < 12; j++) begin
            c = j % 4;
            step(two(c < 2, 0), two(c == 3, 0), '0, $sformatf("t2_new_%0d", j));
        end

        // write landing exactly on the wrap edge
        step(two(1, 0), '0, '0, "t3_c0");
        wr(0, 8, 5, 0);
        step(two(1, 0), '0, two(1, 0), "t3_write1");
        idle();
        step('0, '0, two(1, 0), "t3_c2");
        wr(0, 6, 1, 0);
        step('0, two(1, 0), two(1, 0), "t3_write_on_wrap");
        idle();
        for (int j = 0; j < 8; j++)
            step(two(j < 5, 0), two(j == 7, 0), two(j != 7, 0), $sformatf("t3_mid_%0d", j));
        for (int j = 0; j < 6; j++)
            step(two(j < 1, 0), two(j == 5, 0), '0, $sformatf("t3_last_%0d", j));

        // phase alignment via sync_restart
        ch_enable = '0;
        wr(0, 8, 4, 0);
        step('0, '0, two(1, 0), "t4_wr0");
        wr(1, 8, 4, 4);
        step('0, '0, two(0, 1), "t4_wr1");
        idle();
        step('0, '0, '0, "t4_commit");
        ch_enable    = two(1, 1);
        sync_restart = 1'b1;
        step(two(1, !PH), '0, '0, "t4_restart");
        sync_restart = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            c  = (j - 1) % 8;
            c1 = (j - 1 + (PH ? 4 : 0)) % 8;
            step(two(c < 4, c1 < 4), two(c == 7, c1 == 7), '0, $sformatf("t4_run_%0d", j));
        end

        // writes to nonexistent channels
        ch_enable = '0;
        wr(7, int'($urandom_range(1, 50)), int'($urandom_range(0, 50)), 0);
        step('0, '0, '0, "bad_ch7");
        wr(6, int'($urandom_range(1, 50)), int'($urandom_range(0, 50)), 0);
        step('0, '0, '0, "bad_ch6");
        idle();

        // degenerate settings table on ch2
        for (int v = 0; v < 8; v++) begin
            ch_enable = '0;
            wr(2, vecs[v].d, vecs[v].h, 0);
            step('0, '0, NC'(4), $sformatf("deg%0d_write", v));
            idle();
            repeat ($urandom_range(1, 3)) step('0, '0, '0, $sformatf("deg%0d_gap", v));
            ch_enable = NC'(4);
            hi = 0;
            tk = 0;
            for (int j = 0; j < 20; j++) begin
                @(posedge CLOCK_IN);
                hi += int'(CLOCK_OUT[2]);
                tk += int'(PERIOD_TICK[2]);
            end
            chk($sformatf("deg%0d_high", v), 32'(hi), 32'(vecs[v].exp_hi));
            chk($sformatf("deg%0d_tick", v), 32'(tk), 32'(vecs[v].exp_tk));
        end

        // asynchronous reset mid-period
        ch_enable = '0;
        wr(0, 10, 3, 0);
        step('0, '0, two(1, 0), "t6_write");
        idle();
        step('0, '0, '0, "t6_commit");
        ch_enable = two(1, 0);
        step(two(1, 0), '0, '0, "t6_c0");
        step(two(1, 0), '0, '0, "t6_c1");
        #2 async_reset = 1'b0;
        #1 chk("t6_async_clear", 32'({CLOCK_OUT, PERIOD_TICK, cfg_pending}), 32'd0);
        @(posedge CLOCK_IN);
        async_reset = 1'b1;
        for (int j = 0; j < 12; j++) step('0, '0, '0, $sformatf("t6_after_%0d", j));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
